// File: rtl/fpga_cam_ctrl.sv
// Front-end scheduler for one fpga_cam: round-robin lookup arbitration, write
// interleaving with hazard spacing, and ID-tagged result return.
module fpga_cam_ctrl #(
  parameter int DEPTH     = 512,
  parameter int WIDTH     = 36,
  parameter int NREQ      = 4,
  parameter int LAT       = 4,
  parameter int WR_GAP    = 2,
  parameter int WR_STARVE = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(LAT + 3)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       lk_valid,
  input  logic [NREQ*WIDTH-1:0] lk_patt,
  output logic [NREQ-1:0]       lk_ready,
  input  logic                  wr_valid,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_patt,
  input  logic [WIDTH-1:0]      wr_mask,
  output logic                  wr_ready,
  output logic                  cam_wEn,
  output logic [AW-1:0]         cam_wAddr,
  output logic [WIDTH-1:0]      cam_wPatt,
  output logic [WIDTH-1:0]      cam_wMask,
  output logic [WIDTH-1:0]      cam_mPatt,
  input  logic                  cam_match,
  input  logic [AW-1:0]         cam_mAddr,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic                  rsp_match,
  output logic [AW-1:0]         rsp_addr,
  output logic [CW-1:0]         inflight
);

  localparam int GW = $clog2(WR_GAP + 1);
  localparam int SW = $clog2(WR_STARVE + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [GW-1:0]     gap_r;
  logic [SW-1:0]     starve_r;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     win_s;
  logic              win_found_s;
  logic [IW:0]       idx_s;
  logic              any_lk_s;
  logic              idle_s;
  logic              grant_wr_s;
  logic              grant_lk_s;
  logic [LAT:0]      tag_v_r;
  logic [IW-1:0]     tag_id_r [LAT+1];

  assign any_lk_s   = |lk_valid;
  assign idle_s     = rst_n && (state_r == ST_IDLE);
  // A pending lookup overrides the write once the starve counter saturates.
  assign grant_wr_s = idle_s && wr_valid && !(any_lk_s && (starve_r == SW'(WR_STARVE)));
  assign grant_lk_s = idle_s && any_lk_s && !grant_wr_s;
  assign wr_ready   = grant_wr_s;
  assign lk_ready   = grant_lk_s ? ({{(NREQ-1){1'b0}}, 1'b1} << win_s) : {NREQ{1'b0}};

  // Round-robin search: first asserted request at or after rr_ptr_r.
  always_comb begin
    win_s       = {IW{1'b0}};
    win_found_s = 1'b0;
    idx_s       = {(IW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, rr_ptr_r} + (IW+1)'(k);
      if (idx_s >= (IW+1)'(NREQ)) begin
        idx_s = idx_s - (IW+1)'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!win_found_s && lk_valid[idx_s[IW-1:0]]) begin
        win_s       = idx_s[IW-1:0];
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic for the write/gap sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_wr_s) state_nxt_s = ST_WR;
        else            state_nxt_s = ST_IDLE;
      end
      ST_WR:   state_nxt_s = ST_GAP;
      ST_GAP: begin
        if (gap_r == GW'(1)) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state, arbitration pointer and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      gap_r    <= {GW{1'b0}};
      starve_r <= {SW{1'b0}};
      rr_ptr_r <= {IW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_WR)       gap_r <= GW'(WR_GAP);
      else if (state_r == ST_GAP) gap_r <= gap_r - GW'(1);
      else                        gap_r <= gap_r;
      if (grant_lk_s) begin
        starve_r <= {SW{1'b0}};
        rr_ptr_r <= (win_s == IW'(NREQ - 1)) ? {IW{1'b0}} : win_s + IW'(1);
      end else if (grant_wr_s && any_lk_s && (starve_r != SW'(WR_STARVE))) begin
        starve_r <= starve_r + SW'(1);
      end else begin
        starve_r <= starve_r;
      end
    end
  end

  // CAM write/lookup port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cam_wEn   <= 1'b0;
      cam_wAddr <= {AW{1'b0}};
      cam_wPatt <= {WIDTH{1'b0}};
      cam_wMask <= {WIDTH{1'b0}};
      cam_mPatt <= {WIDTH{1'b0}};
    end else begin
      cam_wEn <= grant_wr_s;
      if (grant_wr_s) begin
        cam_wAddr <= wr_addr;
        cam_wPatt <= wr_patt;
        cam_wMask <= wr_mask;
      end else begin
        cam_wAddr <= cam_wAddr;
      end
      if (grant_lk_s) cam_mPatt <= lk_patt[win_s*WIDTH +: WIDTH];
      else            cam_mPatt <= cam_mPatt;
    end
  end

  // Tag pipeline tracks each lookup through the CAM latency; tail gates the result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v_r   <= {(LAT+1){1'b0}};
      for (int k = 0; k <= LAT; k++) tag_id_r[k] <= {IW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_id    <= {IW{1'b0}};
      rsp_match <= 1'b0;
      rsp_addr  <= {AW{1'b0}};
      inflight  <= {CW{1'b0}};
    end else begin
      tag_v_r     <= {tag_v_r[LAT-1:0], grant_lk_s};
      tag_id_r[0] <= win_s;
      for (int k = 1; k <= LAT; k++) tag_id_r[k] <= tag_id_r[k-1];
      rsp_valid <= tag_v_r[LAT];
      rsp_id    <= tag_v_r[LAT] ? tag_id_r[LAT] : {IW{1'b0}};
      rsp_match <= tag_v_r[LAT] ? cam_match : 1'b0;
      rsp_addr  <= tag_v_r[LAT] ? cam_mAddr : {AW{1'b0}};
      case ({grant_lk_s, rsp_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cam_ctrl.sv
// Self-checking bench for fpga_cam_ctrl: behavioural CAM, transaction-level
// reference model with a response scoreboard, directed scenarios then random traffic.
module tb_fpga_cam_ctrl;
  localparam int DEPTH = 512, WIDTH = 36, NREQ = 4, LAT = 4, WR_GAP = 2, WR_STARVE = 8;
  localparam int AW = $clog2(DEPTH), IW = $clog2(NREQ), CW = $clog2(LAT + 3);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [NREQ-1:0]       lk_valid, lk_ready;
  logic [NREQ*WIDTH-1:0] lk_patt;
  logic                  wr_valid, wr_ready;
  logic [AW-1:0]         wr_addr, cam_wAddr, cam_mAddr, rsp_addr;
  logic [WIDTH-1:0]      wr_patt, wr_mask, cam_wPatt, cam_wMask, cam_mPatt;
  logic                  cam_wEn, cam_match, rsp_valid, rsp_match;
  logic [IW-1:0]         rsp_id;
  logic [CW-1:0]         inflight;

  fpga_cam_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT),
                  .WR_GAP(WR_GAP), .WR_STARVE(WR_STARVE)) dut (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_patt(lk_patt), .lk_ready(lk_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_patt(wr_patt), .wr_mask(wr_mask),
    .wr_ready(wr_ready), .cam_wEn(cam_wEn), .cam_wAddr(cam_wAddr), .cam_wPatt(cam_wPatt),
    .cam_wMask(cam_wMask), .cam_mPatt(cam_mPatt), .cam_match(cam_match),
    .cam_mAddr(cam_mAddr), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_match(rsp_match),
    .rsp_addr(rsp_addr), .inflight(inflight)
  );

  // Two tables: one written by the DUT's CAM port, one shadowed from accepted requests.
  bit [WIDTH-1:0] cam_tp [DEPTH];
  bit [WIDTH-1:0] cam_tm [DEPTH];
  bit             cam_tv [DEPTH];
  bit [WIDTH-1:0] sh_tp  [DEPTH];
  bit [WIDTH-1:0] sh_tm  [DEPTH];
  bit             sh_tv  [DEPTH];
  logic [AW:0]    cam_pipe [LAT];
  logic [WIDTH-1:0] pool [4];

  // Mask bit set = don't care; lowest matching address wins.
  function automatic logic [AW:0] search(input bit use_sh, input logic [WIDTH-1:0] key);
    for (int a = 0; a < DEPTH; a++) begin
      if (use_sh) begin
        if (sh_tv[a] && (((key ^ sh_tp[a]) & ~sh_tm[a]) == '0)) return {1'b1, AW'(a)};
      end else begin
        if (cam_tv[a] && (((key ^ cam_tp[a]) & ~cam_tm[a]) == '0)) return {1'b1, AW'(a)};
      end
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) cam_pipe[k] <= cam_pipe[k-1];
    cam_pipe[0] <= search(1'b0, cam_mPatt);
    if (cam_wEn === 1'b1) begin
      cam_tv[cam_wAddr] <= 1'b1;
      cam_tp[cam_wAddr] <= cam_wPatt;
      cam_tm[cam_wAddr] <= cam_wMask;
    end
  end
  assign cam_match = cam_pipe[LAT-1][AW];
  assign cam_mAddr = cam_pipe[LAT-1][AW-1:0];

  typedef struct { int due; int id; bit m; int addr; } exp_t;
  exp_t sbq[$];

  int cyc, blk, rr, starve, e_win, last_grant;
  int n_chk, n_pass;
  bit chk_en;
  logic            e_wen, e_wr_rdy;
  logic [NREQ-1:0] e_lk_rdy, obs_lk_rdy;
  logic            obs_wr_rdy;
  logic [AW-1:0]   e_waddr;
  logic [WIDTH-1:0] e_wpatt, e_wmask, e_mpatt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Grants the reference expects from the current inputs.
  task automatic decide();
    bit any;
    any      = |lk_valid;
    e_wr_rdy = (rst_n === 1'b1) && (blk == 0) && wr_valid && !(any && starve == WR_STARVE);
    e_lk_rdy = '0;
    e_win    = -1;
    if ((rst_n === 1'b1) && (blk == 0) && any && !e_wr_rdy)
      for (int k = 0; k < NREQ; k++)
        if (e_win < 0 && lk_valid[(rr + k) % NREQ]) e_win = (rr + k) % NREQ;
    if (e_win >= 0) e_lk_rdy[e_win] = 1'b1;
  endtask

  // Reference effect of the upcoming clock edge.
  task automatic advance();
    logic [AW:0] res;
    last_grant = -1;
    cyc++;
    e_wen = 1'b0;
    if (rst_n !== 1'b1) begin
      sbq.delete();
      rr = 0; starve = 0; blk = 0; e_mpatt = '0;
    end else if (e_wr_rdy) begin
      e_wen = 1'b1; e_waddr = wr_addr; e_wpatt = wr_patt; e_wmask = wr_mask;
      sh_tv[wr_addr] = 1'b1; sh_tp[wr_addr] = wr_patt; sh_tm[wr_addr] = wr_mask;
      blk = WR_GAP + 1;
      if ((|lk_valid) && starve < WR_STARVE) starve++;
      last_grant = NREQ;
    end else if (e_win >= 0) begin
      e_mpatt = lk_patt[e_win*WIDTH +: WIDTH];
      res = search(1'b1, e_mpatt);
      sbq.push_back('{cyc + LAT + 1, e_win, res[AW], int'(res[AW-1:0])});
      rr = (e_win + 1) % NREQ;
      starve = 0;
      last_grant = e_win;
    end else if (blk > 0) begin
      blk--;
    end
  endtask

  // One clock: check outputs mid-cycle against the reference, then step it.
  task automatic tick();
    #1;
    decide();
    obs_lk_rdy = lk_ready;
    obs_wr_rdy = wr_ready;
    while (sbq.size() > 0 && sbq[0].due < cyc) void'(sbq.pop_front());
    if (chk_en) begin
      chk("lk_ready", 64'(lk_ready), 64'(e_lk_rdy));
      chk("wr_ready", 64'(wr_ready), 64'(e_wr_rdy));
      chk("cam_wEn", 64'(cam_wEn), 64'(e_wen));
      if (e_wen) begin
        chk("cam_wAddr", 64'(cam_wAddr), 64'(e_waddr));
        chk("cam_wPatt", 64'(cam_wPatt), 64'(e_wpatt));
        chk("cam_wMask", 64'(cam_wMask), 64'(e_wmask));
      end
      chk("cam_mPatt", 64'(cam_mPatt), 64'(e_mpatt));
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_id", 64'(rsp_id), 64'(sbq[0].id));
        chk("rsp_match", 64'(rsp_match), 64'(sbq[0].m));
        chk("rsp_addr", 64'(rsp_addr), 64'(sbq[0].addr));
      end else begin
        chk("rsp_valid idle", 64'(rsp_valid), 64'(0));
        chk("rsp_match idle", 64'(rsp_match), 64'(0));
        chk("rsp_addr idle", 64'(rsp_addr), 64'(0));
      end
      chk("inflight", 64'(inflight), 64'(sbq.size()));
    end
    advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lk_valid = '0; wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  initial begin
    int nr, rid, first_i, last_i, wen_i, lk_i, n_wen, found, fm, fa;
    int ids[$];
    int g[$];
    n_chk = 0; n_pass = 0; cyc = 0; blk = 0; rr = 0; starve = 0; chk_en = 1'b0;
    e_wen = 1'b0; e_mpatt = '0; e_waddr = '0; e_wpatt = '0; e_wmask = '0;
    pool[0] = 36'h0_0000_0ABC; pool[1] = 36'h1_2345_6789;
    pool[2] = 36'hF_0F0F_0F0F; pool[3] = 36'h0_DEAD_BEEF;
    for (int k = 0; k < LAT; k++) cam_pipe[k] = '0;
    rst_n = 1'b0; lk_valid = '0; lk_patt = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_patt = '0; wr_mask = '0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Single lookup from requester 2
    lk_patt[2*WIDTH +: WIDTH] = pool[1];
    lk_valid = 4'b0100;
    tick();
    chk("single grant", 64'(obs_lk_rdy), 64'(4'b0100));
    lk_valid = '0;
    nr = 0; rid = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid === 1'b1) begin nr++; rid = rsp_id; end
    end
    chk("single rsp count", 64'(nr), 64'(1));
    chk("single rsp id", 64'(rid), 64'(2));

    // Round-robin with all requesters active
    do_reset();
    for (int k = 0; k < NREQ; k++) lk_patt[k*WIDTH +: WIDTH] = pool[k];
    first_i = -1; last_i = -1;
    for (int i = 0; i < 20; i++) begin
      lk_valid = (i < 8) ? 4'b1111 : 4'b0000;
      tick();
      if (i < 8) chk("rr grant", 64'(obs_lk_rdy), 64'(4'b0001 << (i % NREQ)));
      if (rsp_valid === 1'b1) begin
        ids.push_back(int'(rsp_id));
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    chk("rr rsp count", 64'(ids.size()), 64'(8));
    for (int i = 0; i < ids.size(); i++) chk("rr rsp id", 64'(ids[i]), 64'(i % NREQ));
    chk("rr rsp back-to-back", 64'(last_i - first_i), 64'(7));

    // Write then lookup of the written pattern
    do_reset();
    wr_valid = 1'b1; wr_addr = 9'd5; wr_patt = 36'hABC; wr_mask = '0;
    lk_valid = 4'b0001; lk_patt[0 +: WIDTH] = 36'hABC;
    wen_i = -100; lk_i = -1; n_wen = 0; found = 0; fm = 0; fa = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_wr_rdy === 1'b1) wr_valid = 1'b0;
      if (cam_wEn === 1'b1) begin n_wen++; wen_i = i + 1; end
      if (obs_lk_rdy[0] === 1'b1) begin lk_i = i; lk_valid = '0; end
      if (rsp_valid === 1'b1) begin found++; fm = rsp_match; fa = rsp_addr; end
    end
    chk("write pulse count", 64'(n_wen), 64'(1));
    chk("write-to-lookup gap", 64'(lk_i - wen_i), 64'(WR_GAP + 1));
    chk("wl rsp count", 64'(found), 64'(1));
    chk("wl rsp match", 64'(fm), 64'(1));
    chk("wl rsp addr", 64'(fa), 64'(5));

    // Starvation limit
    do_reset();
    wr_valid = 1'b1; wr_addr = 9'd100; wr_patt = '0; wr_mask = '0;
    lk_valid = 4'b0010; lk_patt[WIDTH +: WIDTH] = pool[2];
    for (int i = 0; i < 40; i++) begin
      tick();
      if (obs_wr_rdy === 1'b1) g.push_back(NREQ);
      else if (obs_lk_rdy != '0) g.push_back(onehot_idx(obs_lk_rdy));
    end
    chk("starve grant count", 64'(g.size() >= 10), 64'(1));
    if (g.size() >= 10) begin
      for (int i = 0; i < WR_STARVE; i++) chk("starve write grant", 64'(g[i]), 64'(NREQ));
      chk("starve lookup grant", 64'(g[WR_STARVE]), 64'(1));
      chk("starve write resumes", 64'(g[WR_STARVE+1]), 64'(NREQ));
    end
    wr_valid = 1'b0; lk_valid = '0;

    // Reset while lookups are in flight
    do_reset();
    lk_valid = 4'b1111;
    tick(); tick(); tick();
    lk_valid = '0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nr = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b0) nr++;
    end
    chk("no rsp after reset", 64'(nr), 64'(0));
    chk("inflight after reset", 64'(inflight), 64'(0));
    chk("cam_wEn after reset", 64'(cam_wEn), 64'(0));
    lk_valid = 4'b1111;
    tick();
    chk("rr restart", 64'(obs_lk_rdy), 64'(4'b0001));
    lk_valid = '0;

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      lk_valid = ($urandom_range(0, 9) < 4) ? 4'b0000 : NREQ'($urandom_range(0, 15));
      wr_valid = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < NREQ; k++) lk_patt[k*WIDTH +: WIDTH] = pool[$urandom_range(0, 3)];
      wr_addr  = AW'($urandom_range(0, 15));
      wr_patt  = pool[$urandom_range(0, 3)];
      wr_mask  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255)) : '0;
      tick();
    end
    rst_n = 1'b1; lk_valid = '0; wr_valid = 1'b0;
    for (int i = 0; i < LAT + 6; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
